hsci_xfer_sched: RTL and testbench

Round-robin scheduler that shares the single HSCI master core between NUM_REQ independent transaction requesters in the `hsci_pclk` domain. It accepts one transaction descriptor at a time, drives the master core's command fields and one-cycle run strobe, and tracks the transaction to completion or timeout. It then returns a status pulse to the owning requester. It sits between the requester logic (register-sequencer, calibration engine, etc.) and the HSCI master core command/status ports, replacing the direct register-driven run path.

---
 rtl/hsci_xfer_sched.sv | 178 +++++++++++++++++
 tb/tb_hsci_xfer_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hsci_xfer_sched.sv
// Round-robin scheduler sharing one HSCI master core between NUM_REQ requesters.
// Launches one descriptor at a time and reports completion or timeout to its owner.
module hsci_xfer_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                   hsci_pclk,
  input  logic                   hsci_rst_sync,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*40-1:0]  req_desc,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_timeout,
  output logic                   mst_run,
  output logic [1:0]             mst_cmd_sel,
  output logic [15:0]            mst_xfer_num,
  output logic [2:0]             mst_byte_num,
  output logic [2:0]             mst_addr_size,
  output logic [14:0]            mst_bram_addr,
  input  logic                   mst_running,
  input  logic                   mst_done,
  input  logic                   link_active,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [15:0]            done_cnt,
  output logic [15:0]            timeout_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           rr_ptr_q, grant_q;
  logic [CW-1:0]        tmo_q;
  logic [NUM_REQ-1:0]   req_ready_q, rsp_valid_q;
  logic                 rsp_timeout_q, mst_run_q, busy_q;
  logic [1:0]           cmd_sel_q;
  logic [15:0]          xfer_num_q;
  logic [2:0]           byte_num_q, addr_size_q;
  logic [14:0]          bram_addr_q;
  logic [15:0]          done_cnt_q, timeout_cnt_q;

  logic [2*NUM_REQ-1:0] dbl_req, rot_shift;
  logic [NUM_REQ-1:0]   rot_req, win_oh, own_oh;
  logic [2:0]           win_off, win_id;
  logic [3:0]           win_sum;
  logic                 win_found, launch, timed_out, tc_hit;
  logic [39:0]          win_desc;

  // Rotate the request vector so offset 0 is rr_ptr, then take the first set bit.
  always_comb begin
    dbl_req   = {req_valid, req_valid};
    rot_shift = dbl_req >> rr_ptr_q;
    rot_req   = rot_shift[NUM_REQ-1:0];
    win_found = 1'b0;
    win_off   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found && rot_req[k]) begin
        win_found = 1'b1;
        win_off   = 3'(k);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= 4'(NUM_REQ)) win_sum = win_sum - 4'(NUM_REQ);
    win_id   = win_sum[2:0];
    win_desc = '0;
    win_oh   = '0;
    own_oh   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == win_id) begin
        win_desc  = req_desc[40*k +: 40];
        win_oh[k] = 1'b1;
      end
      own_oh[k] = (3'(k) == grant_q);
    end
  end

  assign launch = (state_q == S_IDLE) && link_active && win_found;
  assign tc_hit = (tmo_q == TC);

  always_comb begin
    state_d   = state_q;
    timed_out = 1'b0;
    case (state_q)
      S_IDLE:       if (launch) state_d = S_LAUNCH;
      S_LAUNCH:     state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (mst_running) begin
          state_d = S_WAIT_DONE;
        end else if (tc_hit) begin
          state_d   = S_RESP;
          timed_out = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (mst_done && !mst_running) begin
          state_d = S_RESP;
        end else if (tc_hit) begin
          state_d   = S_RESP;
          timed_out = 1'b1;
        end
      end
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst_sync) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      tmo_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_timeout_q <= 1'b0;
      mst_run_q     <= 1'b0;
      busy_q        <= 1'b0;
      cmd_sel_q     <= '0;
      xfer_num_q    <= '0;
      byte_num_q    <= '0;
      addr_size_q   <= '0;
      bram_addr_q   <= '0;
      done_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != S_IDLE);
      mst_run_q     <= launch;
      req_ready_q   <= launch ? win_oh : '0;
      rsp_valid_q   <= (state_d == S_RESP) ? own_oh : '0;
      rsp_timeout_q <= (state_d == S_RESP) && timed_out;

      // Counter starts at 0 in LAUNCH and counts it, so terminal count lands
      // TIMEOUT_CYCLES-1 cycles after LAUNCH; it saturates there.
      if (launch) begin
        grant_q     <= win_id;
        bram_addr_q <= win_desc[14:0];
        xfer_num_q  <= win_desc[30:15];
        cmd_sel_q   <= win_desc[32:31];
        addr_size_q <= win_desc[35:33];
        byte_num_q  <= win_desc[38:36];
        tmo_q       <= '0;
      end else if (state_q inside {S_LAUNCH, S_WAIT_START, S_WAIT_DONE} && !tc_hit) begin
        tmo_q <= tmo_q + CW'(1);
      end

      if (state_q == S_RESP) begin
        if (rsp_timeout_q) timeout_cnt_q <= timeout_cnt_q + 16'd1;
        else               done_cnt_q    <= done_cnt_q + 16'd1;
        rr_ptr_q <= (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign mst_run       = mst_run_q;
  assign mst_cmd_sel   = cmd_sel_q;
  assign mst_xfer_num  = xfer_num_q;
  assign mst_byte_num  = byte_num_q;
  assign mst_addr_size = addr_size_q;
  assign mst_bram_addr = bram_addr_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign done_cnt      = done_cnt_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_hsci_xfer_sched.sv
// Bench for hsci_xfer_sched: directed scenarios plus randomized transactions
// checked against a round-robin / latency reference model.
module tb_hsci_xfer_sched;

  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [159:0] req_desc;
  logic [3:0]  req_ready, rsp_valid;
  logic        rsp_timeout, mst_run;
  logic [1:0]  mst_cmd_sel;
  logic [15:0] mst_xfer_num;
  logic [2:0]  mst_byte_num, mst_addr_size;
  logic [14:0] mst_bram_addr;
  logic        mst_running, mst_done, link_active, busy;
  logic [2:0]  grant_id;
  logic [15:0] done_cnt, timeout_cnt;

  logic [39:0] dsc [4];
  assign req_desc = {dsc[3], dsc[2], dsc[1], dsc[0]};

  hsci_xfer_sched #(.NUM_REQ(4), .TIMEOUT_CYCLES(TMO)) dut (
    .hsci_pclk(clk), .hsci_rst_sync(rst),
    .req_valid(req_valid), .req_desc(req_desc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .mst_run(mst_run), .mst_cmd_sel(mst_cmd_sel), .mst_xfer_num(mst_xfer_num),
    .mst_byte_num(mst_byte_num), .mst_addr_size(mst_addr_size),
    .mst_bram_addr(mst_bram_addr), .mst_running(mst_running), .mst_done(mst_done),
    .link_active(link_active), .busy(busy), .grant_id(grant_id),
    .done_cnt(done_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master core model: running rises m_run_lat cycles after the run strobe,
  // done (with running low) m_done_lat cycles later; <=0 means never.
  int m_run_lat = -1, m_done_lat = -1, m_age = 0;
  bit m_act = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0; mst_running = 1'b0; mst_done = 1'b0;
    end else if (mst_run) begin
      m_act = 1'b1; m_age = 0; mst_running = 1'b0; mst_done = 1'b0;
    end else if (m_act) begin
      m_age++;
      if (m_run_lat > 0 && m_age == m_run_lat) mst_running = 1'b1;
      if (m_run_lat > 0 && m_done_lat > 0 && m_age == m_run_lat + m_done_lat) begin
        mst_running = 1'b0; mst_done = 1'b1; m_act = 1'b0;
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int mdl_ptr = 0, mdl_done = 0, mdl_to = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] m);
    for (int off = 0; off < 4; off++) begin
      int i = (ptr + off) % 4;
      if (m[2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [84:0] all_outs();
    return {req_ready, rsp_valid, rsp_timeout, mst_run, mst_cmd_sel, mst_xfer_num,
            mst_byte_num, mst_addr_size, mst_bram_addr, busy, grant_id,
            done_cnt, timeout_cnt};
  endfunction

  task automatic rand_desc();
    for (int i = 0; i < 4; i++) dsc[2'(i)] = {8'($urandom), $urandom};
  endtask

  // One full transaction from IDLE; T is the cycle req_valid is first seen.
  task automatic do_xfer(input logic [3:0] mask, input int rl, input int dl,
                         input bit hold, input logic [3:0] glitch);
    int g, T, L, R, age;
    bit exp_to;
    logic extra;
    g = rr_pick(mdl_ptr, mask);
    m_run_lat = rl; m_done_lat = dl;
    req_valid = mask;
    T = int'(cyc);
    L = T + 1;
    age = (rl > 0 && dl > 0) ? rl + dl : 1000;
    exp_to = (age > TMO - 1);
    R = exp_to ? L + TMO : L + age + 1;
    tick();
    chk("launch_run", mst_run, 1'b1);
    chk("launch_ready", req_ready, 4'(4'd1 << g));
    chk("launch_grant", grant_id, 3'(g));
    chk("launch_busy", busy, 1'b1);
    chk("fields", {mst_byte_num, mst_addr_size, mst_cmd_sel, mst_xfer_num, mst_bram_addr},
        dsc[2'(g)][38:0]);
    if (!hold) req_valid = '0;
    extra = 1'b0;
    while (rsp_valid == '0 && int'(cyc) < R + 8) begin
      tick();
      extra |= mst_run | (|req_ready);
      if (glitch != '0 && int'(cyc) == L + 4) req_valid = glitch;
      if (glitch != '0 && int'(cyc) == L + 5) req_valid = hold ? mask : '0;
    end
    chk("rsp_cycle", cyc, R);
    chk("rsp_valid", rsp_valid, 4'(4'd1 << g));
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("no_extra_launch", extra, 1'b0);
    tick();
    if (exp_to) mdl_to++; else mdl_done++;
    mdl_ptr = (g + 1) % 4;
    chk("idle_busy", busy, 1'b0);
    chk("rsp_pulse_end", rsp_valid, 4'b0);
    chk("done_cnt", done_cnt, 16'(mdl_done));
    chk("timeout_cnt", timeout_cnt, 16'(mdl_to));
  endtask

  task automatic idle_check(input int n, input string tag);
    logic act;
    act = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      act |= mst_run | busy | (|req_ready) | (|rsp_valid);
    end
    chk(tag, act, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    rst = 1'b1; link_active = 1'b0; req_valid = '0;
    rand_desc();
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 85'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 2.
    link_active = 1'b1;
    dsc[2] = {1'b0, 3'd2, 3'd1, 2'd1, 16'd3, 15'h0010};
    do_xfer(4'b0100, 2, 20, 1'b0, '0);

    // Fairness with all requests held, then pointer-relative pick.
    rand_desc();
    for (int i = 0; i < 5; i++) do_xfer(4'b1111, 1, 1, (i < 4), '0);
    do_xfer(4'b0010, 1, 1, 1'b0, '0);
    do_xfer(4'b0011, 1, 2, 1'b0, '0);

    // Timeout, done on terminal count, done one cycle late.
    do_xfer(4'b0001, -1, -1, 1'b0, '0);
    do_xfer(4'b0010, 2, 29, 1'b0, '0);
    do_xfer(4'b0100, 2, 30, 1'b0, '0);

    // Link gating.
    link_active = 1'b0;
    req_valid = 4'b0001;
    idle_check(50, "link_gated");
    link_active = 1'b1;
    do_xfer(4'b0001, 1, 3, 1'b0, '0);

    // Withdrawn request during another owner's transfer.
    do_xfer(4'b1000, 2, 10, 1'b0, 4'b0010);
    idle_check(10, "no_stale_launch");

    // Reset mid-transfer; pointer left at 2 beforehand.
    do_xfer(4'b0010, 1, 1, 1'b0, '0);
    m_run_lat = 2; m_done_lat = 25;
    req_valid = 4'b0100;
    tick();
    L = int'(cyc);
    chk("abort_launch", {mst_run, grant_id}, {1'b1, 3'd2});
    req_valid = '0;
    while (int'(cyc) < L + 4) tick();
    rst = 1'b1;
    tick();
    chk("midreset_outputs", all_outs(), 85'd0);
    rst = 1'b0;
    mdl_ptr = 0; mdl_done = 0; mdl_to = 0;
    idle_check(40, "no_abort_rsp");
    do_xfer(4'b1111, 1, 2, 1'b0, '0);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      int rl, dl;
      logic [3:0] m;
      m  = 4'($urandom_range(1, 15));
      rl = int'($urandom_range(0, 4));
      if (rl == 0) rl = -1;
      dl = int'($urandom_range(1, 34));
      rand_desc();
      do_xfer(m, rl, dl, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
